// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate engine.
//   fir_state_t  : engine FSM state encoding (IDLE, MAC, OUT)
//   FIR_DATA_W   : default sample / coefficient width
//   FIR_NTAPS    : default filter length
package fir_pkg;

    localparam int FIR_DATA_W = 4;
    localparam int FIR_NTAPS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_mac_engine_if.sv
// Bundle of the sample-in, coefficient-write and result-out signals.
//   in_valid/in_data/in_ready      : sample stream into the engine
//   tap_we/tap_addr/tap_wdata      : coefficient write port
//   out_valid/out_data/out_ready   : filtered result stream
// master = the side that feeds samples/taps and consumes results,
// slave  = the engine itself.
interface fir_mac_engine_if
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int NTAPS  = FIR_NTAPS,
    parameter int ACC_W  = 2 * DATA_W + $clog2(NTAPS)
);
    logic                       in_valid;
    logic signed [DATA_W-1:0]   in_data;
    logic                       in_ready;
    logic                       tap_we;
    logic [$clog2(NTAPS)-1:0]   tap_addr;
    logic signed [DATA_W-1:0]   tap_wdata;
    logic                       out_valid;
    logic signed [ACC_W-1:0]    out_data;
    logic                       out_ready;

    modport master (
        output in_valid, in_data, tap_we, tap_addr, tap_wdata, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, tap_we, tap_addr, tap_wdata, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/tap_mult.sv
// Combinational signed multiplier, DATA_W x DATA_W -> 2*DATA_W.
//   a, b : signed operands
//   p    : full-precision signed product
module tap_mult #(
    parameter int DATA_W = 4
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);
    // Widen both operands first so the product is computed at full width.
    assign p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR filter: one multiply per cycle over NTAPS taps.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : fir_mac_engine_if.slave (sample in, tap write, result out)
// A sample accepted in IDLE is written into a circular delay line; MAC
// then walks k = 0..NTAPS-1 through a registered product stage, and OUT
// holds the accumulator until the downstream handshake.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int NTAPS  = FIR_NTAPS,
    parameter int ACC_W  = 2 * DATA_W + $clog2(NTAPS)
) (
    input  logic           clk,
    input  logic           reset,
    fir_mac_engine_if.slave bus
);
    localparam int AW = $clog2(NTAPS);
    localparam int KW = $clog2(NTAPS) + 1;   // k must reach NTAPS for the drain step

    fir_state_t                 state_q, state_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [KW-1:0]              k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [2*DATA_W-1:0] prod_q, prod_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]   taps_q [NTAPS];
    logic signed [DATA_W-1:0]   taps_d [NTAPS];
    logic signed [DATA_W-1:0]   hist_q [NTAPS];
    logic signed [DATA_W-1:0]   hist_d [NTAPS];

    logic [AW-1:0]              rd_ptr;
    logic signed [2*DATA_W-1:0] mult_p;
    logic signed [ACC_W-1:0]    prod_ext;

    // Newest sample sits at wr_ptr; x[n-k] is k entries behind it.
    assign rd_ptr   = wr_ptr_q - k_q[AW-1:0];
    assign prod_ext = ACC_W'(prod_q);

    tap_mult #(.DATA_W(DATA_W)) u_mult (
        .a (taps_q[k_q[AW-1:0]]),
        .b (hist_q[rd_ptr]),
        .p (mult_p)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        acc_d       = acc_q;
        prod_d      = mult_p;
        out_valid_d = out_valid_q;
        taps_d      = taps_q;
        hist_d      = hist_q;
        case (state_q)
            IDLE: begin
                if (bus.tap_we) begin
                    taps_d[bus.tap_addr] = bus.tap_wdata;
                end
                if (bus.in_valid) begin
                    hist_d[wr_ptr_q] = bus.in_data;
                    acc_d            = '0;
                    k_d              = '0;
                    state_d          = MAC;
                end
            end
            MAC: begin
                // Product for step k is registered, so it is summed one
                // cycle later; step k = NTAPS only drains the last product.
                k_d = k_q + KW'(1);
                if (k_q != '0) begin
                    acc_d = acc_q + prod_ext;
                end
                if (k_q == KW'(NTAPS)) begin
                    k_d         = '0;
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_store
        always_ff @(posedge clk) begin
            if (!reset) begin
                taps_q[gi] <= '0;
                hist_q[gi] <= '0;
            end else begin
                taps_q[gi] <= taps_d[gi];
                hist_q[gi] <= hist_d[gi];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
endmodule

// File: tb/tb_fir_mac_engine.sv
module tb_fir_mac_engine;
    localparam int DATA_W = 4;
    localparam int NTAPS  = 4;
    localparam int ACC_W  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   exp_q[$];
    logic prev_v = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_engine_if #(.DATA_W(DATA_W), .NTAPS(NTAPS), .ACC_W(ACC_W)) bus ();

    fir_mac_engine #(.DATA_W(DATA_W), .NTAPS(NTAPS), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: latency on each rising out_valid, value on each handshake.
    always @(negedge clk) begin
        if (reset && bus.out_valid && !prev_v)
            check("latency", cyc - acc_cyc, NTAPS + 1);
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %0d, expected none", $signed(bus.out_data));
            end else begin
                check("y", int'($signed(bus.out_data)), exp_q.pop_front());
            end
        end
        prev_v = reset && bus.out_valid;
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic signed [DATA_W-1:0] x, input int exp, input bit push);
        bit ok = 1'b0;
        int g  = 0;
        if (push) exp_q.push_back(exp);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (!ok && g < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) check("drain_timeout", 0, 1);
    endtask

    task automatic write_tap(input int a, input int v);
        bus.tap_we    = 1'b1;
        bus.tap_addr  = 2'(a);
        bus.tap_wdata = 4'(v);
        @(posedge clk);
        #1;
        bus.tap_we = 1'b0;
    endtask

    task automatic load_taps(input int t0, input int t1, input int t2, input int t3);
        wait_drain();
        write_tap(0, t0);
        write_tap(1, t1);
        write_tap(2, t2);
        write_tap(3, t3);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int held;
        int g;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.tap_we    = 1'b0;
        bus.tap_addr  = '0;
        bus.tap_wdata = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        check("post_rst_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;

        // Impulse response
        load_taps(1, 2, 3, -1);
        send(4'sd1, 1, 1);
        send(4'sd0, 2, 1);
        send(4'sd0, 3, 1);
        send(4'sd0, -1, 1);
        send(4'sd0, 0, 1);

        // Extreme values: (-8)*(-8) accumulated four times
        load_taps(-8, -8, -8, -8);
        send(-4'sd8, 64, 1);
        send(-4'sd8, 128, 1);
        send(-4'sd8, 192, 1);
        send(-4'sd8, 256, 1);

        // Backpressure: hold out_ready low while a sample is offered
        wait_drain();
        bus.out_ready = 1'b0;
        send(4'sd1, 184, 1);
        g = 0;
        while (!bus.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bp_valid_seen", int'(bus.out_valid), 1);
        held         = int'($signed(bus.out_data));
        bus.in_valid = 1'b1;
        bus.in_data  = 4'sd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", int'($signed(bus.out_data)), held);
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(4'sd2, 104, 1);

        // Tap write during MAC is dropped
        load_taps(1, 2, 3, -1);
        send(4'sd1, 16, 1);
        bus.tap_we    = 1'b1;
        bus.tap_addr  = 2'd0;
        bus.tap_wdata = 4'sd7;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.tap_we = 1'b0;
        send(4'sd1, 8, 1);

        // Reset in the middle of MAC: that result must never appear
        wait_drain();
        send(4'sd1, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midmac_no_valid", int'(bus.out_valid), 0);
        end
        check("midmac_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        send(4'sd1, 0, 1);              // taps cleared by reset
        load_taps(1, 2, 3, -1);
        send(4'sd0, 2, 1);
        send(4'sd0, 3, 1);
        send(4'sd0, -1, 1);
        send(4'sd1, 1, 1);
        send(4'sd0, 2, 1);
        send(4'sd0, 3, 1);
        send(4'sd0, -1, 1);

        // Wrap of the delay line, all-ones taps; tap[3] is written in the
        // same cycle the fourth sample is accepted. Samples 8,9,10 do not
        // fit a 4-bit signed sample and are applied as -8,-7,-6.
        wait_drain();
        write_tap(0, 1);
        write_tap(1, 1);
        write_tap(2, 1);
        send(4'sd1, 1, 1);
        send(4'sd2, 3, 1);
        send(4'sd3, 6, 1);
        bus.tap_we    = 1'b1;
        bus.tap_addr  = 2'd3;
        bus.tap_wdata = 4'sd1;
        send(4'sd4, 10, 1);
        bus.tap_we = 1'b0;
        send(4'sd5, 14, 1);
        send(4'sd6, 18, 1);
        send(4'sd7, 22, 1);
        send(-4'sd8, 10, 1);
        send(-4'sd7, -2, 1);
        send(-4'sd6, -14, 1);

        wait_drain();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
